// File: rtl/axi_router_pkg.sv
// Shared types and helpers for the AXI response router.
// Provides the skid-state enum and the ID-to-one-hot decode.
package axi_router_pkg;

  localparam int ERR_CNT_WIDTH = 8;
  localparam int MAX_PORTS = 32;

  typedef enum logic [1:0] {
    EMPTY,
    ONE,
    FULL
  } skid_state_t;

  function automatic logic [MAX_PORTS-1:0] id_to_onehot(
    input int unsigned id,
    input int unsigned port_num
  );
    logic [MAX_PORTS-1:0] oh;
    oh = '0;
    if (id < port_num) oh = MAX_PORTS'(1) << id;
    return oh;
  endfunction

endpackage

// File: rtl/axi_resp_router_if.sv
// Generic valid/ready stream bundle.
// The master drives valid and data, and the slave drives ready.
interface axi_resp_router_if #(
  parameter int W = 1
);
  logic         valid;
  logic         ready;
  logic [W-1:0] data;

  modport master (output valid, output data, input ready);
  modport slave  (input valid, input data, output ready);
endinterface

// File: rtl/axi_skid_buffer.sv
// Two-entry valid/ready register slice (main + skid).
// Ready is registered, so there is no path from out.ready to in.ready.
module axi_skid_buffer
  import axi_router_pkg::*;
#(
  parameter int DW = 8
) (
  input  logic                 aclk,
  input  logic                 aresetn,
  axi_resp_router_if.slave     in,
  axi_resp_router_if.master    out
);

  skid_state_t   state;
  logic [DW-1:0] main_q;
  logic [DW-1:0] skid_q;
  logic          rdy_q;
  logic          vld;
  logic          acc;
  logic          ret;

  assign vld       = (state != EMPTY);
  assign acc       = in.valid && rdy_q;
  assign ret       = vld && out.ready;
  assign in.ready  = rdy_q;
  assign out.valid = vld;
  assign out.data  = main_q;

  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      state  <= EMPTY;
      main_q <= '0;
      skid_q <= '0;
      rdy_q  <= 1'b1;
    end else begin
      unique case (state)
        EMPTY: begin
          if (acc) begin
            main_q <= in.data;
            state  <= ONE;
          end
        end
        ONE: begin
          if (acc && ret) begin
            main_q <= in.data;
          end else if (acc) begin
            skid_q <= in.data;
            state  <= FULL;
            rdy_q  <= 1'b0;
          end else if (ret) begin
            state  <= EMPTY;
          end
        end
        FULL: begin
          if (ret) begin
            main_q <= skid_q;
            state  <= ONE;
            rdy_q  <= 1'b1;
          end
        end
        default: begin
          state <= EMPTY;
          rdy_q <= 1'b1;
        end
      endcase
    end
  end

endmodule

// File: rtl/axi_resp_router.sv
// Routes one AXI response stream to per-ID master ports.
// Invalid IDs are absorbed and recorded in sticky error status.
module axi_resp_router
  import axi_router_pkg::*;
#(
  parameter int AXI_ID_WIDTH  = 2,
  parameter int AXI_PORT_NUM  = 3,
  parameter int PAYLOAD_WIDTH = 2
) (
  input  logic                     aclk,
  input  logic                     aresetn,
  input  logic [AXI_ID_WIDTH-1:0]  s_id_i,
  input  logic [PAYLOAD_WIDTH-1:0] s_data_i,
  input  logic                     s_valid_i,
  output logic                     s_ready_o,
  output logic [AXI_PORT_NUM-1:0]  m_valid_o,
  input  logic [AXI_PORT_NUM-1:0]  m_ready_i,
  output logic [AXI_ID_WIDTH-1:0]  m_id_o,
  output logic [PAYLOAD_WIDTH-1:0] m_data_o,
  output logic                     err_o,
  output logic [AXI_ID_WIDTH-1:0]  err_id_o,
  output logic [ERR_CNT_WIDTH-1:0] err_cnt_o,
  input  logic                     err_clr_i
);

  localparam int DW = AXI_PORT_NUM + AXI_ID_WIDTH + PAYLOAD_WIDTH;

  axi_resp_router_if #(.W(DW)) sin ();
  axi_resp_router_if #(.W(DW)) sout ();

  logic [AXI_PORT_NUM-1:0] oh;
  logic [AXI_PORT_NUM-1:0] main_oh;
  logic                    inv;

  assign oh = AXI_PORT_NUM'(id_to_onehot(32'(s_id_i), AXI_PORT_NUM));

  // Only routable beats enter the buffer; invalid ones are swallowed here.
  assign sin.valid = s_valid_i && (oh != '0);
  assign sin.data  = {oh, s_id_i, s_data_i};
  assign s_ready_o = sin.ready;
  assign inv       = s_valid_i && s_ready_o && (oh == '0);

  axi_skid_buffer #(.DW(DW)) u_skid (
    .aclk    (aclk),
    .aresetn (aresetn),
    .in      (sin.slave),
    .out     (sout.master)
  );

  assign {main_oh, m_id_o, m_data_o} = sout.data;
  assign m_valid_o  = main_oh & {AXI_PORT_NUM{sout.valid}};
  assign sout.ready = |(m_valid_o & m_ready_i);

  // A new invalid beat wins over a simultaneous clear.
  always_ff @(posedge aclk or negedge aresetn) begin
    if (!aresetn) begin
      err_o     <= 1'b0;
      err_id_o  <= '0;
      err_cnt_o <= '0;
    end else if (err_clr_i) begin
      err_o     <= inv;
      err_id_o  <= inv ? s_id_i : '0;
      err_cnt_o <= inv ? ERR_CNT_WIDTH'(1) : '0;
    end else if (inv) begin
      err_o <= 1'b1;
      if (!err_o) err_id_o <= s_id_i;
      if (err_cnt_o != '1) err_cnt_o <= err_cnt_o + 1'b1;
    end
  end

endmodule

// File: tb/tb_axi_resp_router.sv
// Directed and randomised bench for axi_resp_router.
// Uses hand-computed vectors plus an in-order beat scoreboard.
module tb_axi_resp_router;

  localparam int IW = 2;
  localparam int NP = 3;
  localparam int PW = 2;

  logic          aclk;
  logic          aresetn;
  logic [IW-1:0] s_id;
  logic [NP-1:0] m_valid;
  logic [NP-1:0] m_ready;
  logic [IW-1:0] m_id;
  logic [PW-1:0] m_data;
  logic          err;
  logic [IW-1:0] err_id;
  logic [7:0]    err_cnt;
  logic          err_clr;

  int checks = 0;
  int errors = 0;

  axi_resp_router_if #(.W(PW)) sif ();

  axi_resp_router #(
    .AXI_ID_WIDTH  (IW),
    .AXI_PORT_NUM  (NP),
    .PAYLOAD_WIDTH (PW)
  ) dut (
    .aclk      (aclk),
    .aresetn   (aresetn),
    .s_id_i    (s_id),
    .s_data_i  (sif.data),
    .s_valid_i (sif.valid),
    .s_ready_o (sif.ready),
    .m_valid_o (m_valid),
    .m_ready_i (m_ready),
    .m_id_o    (m_id),
    .m_data_o  (m_data),
    .err_o     (err),
    .err_id_o  (err_id),
    .err_cnt_o (err_cnt),
    .err_clr_i (err_clr)
  );

  initial aclk = 1'b0;
  always #5 aclk = ~aclk;

  task automatic step();
    @(posedge aclk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [IW-1:0] id,
                       input logic [PW-1:0] d);
    sif.valid = v;
    s_id      = id;
    sif.data  = d;
  endtask

  task automatic test_reset();
    aresetn = 1'b1;
    drive(1'b0, '0, '0);
    m_ready = '0;
    err_clr = 1'b0;
    #1 aresetn = 1'b0;
    #1;
    checks++;
    if (m_valid !== 3'b000) begin
      errors++;
      $display("FAIL rst_m_valid got %b want 000", m_valid);
    end
    checks++;
    if (sif.ready !== 1'b1) begin
      errors++;
      $display("FAIL rst_s_ready got %b want 1", sif.ready);
    end
    checks++;
    if ({m_id, m_data} !== 4'h0) begin
      errors++;
      $display("FAIL rst_m_id_data got %h want 0", {m_id, m_data});
    end
    checks++;
    if ({err, err_id, err_cnt} !== 11'h0) begin
      errors++;
      $display("FAIL rst_err got %b/%0d/%0d want 0/0/0",
               err, err_id, err_cnt);
    end
    step();
    aresetn = 1'b1;
    step();
  endtask

  task automatic test_back_to_back();
    logic [NP-1:0] ev [3];
    ev[0] = 3'b001;
    ev[1] = 3'b010;
    ev[2] = 3'b100;
    m_ready = 3'b111;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, IW'(i), PW'(i + 1));
      step();
      checks++;
      if (m_valid !== ev[i] || m_id !== IW'(i) || m_data !== PW'(i + 1)) begin
        errors++;
        $display("FAIL b2b_beat%0d got v=%b id=%0d d=%0d want v=%b id=%0d d=%0d",
                 i, m_valid, m_id, m_data, ev[i], i, i + 1);
      end
      checks++;
      if (sif.ready !== 1'b1) begin
        errors++;
        $display("FAIL b2b_ready%0d got %b want 1", i, sif.ready);
      end
    end
    drive(1'b0, '0, '0);
    step();
    checks++;
    if (m_valid !== 3'b000) begin
      errors++;
      $display("FAIL b2b_drain got %b want 000", m_valid);
    end
  endtask

  task automatic test_stall();
    m_ready = 3'b101;
    drive(1'b1, 2'd1, 2'd1);
    step();
    checks++;
    if (m_valid !== 3'b010 || sif.ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_first got v=%b r=%b want v=010 r=1",
               m_valid, sif.ready);
    end
    drive(1'b1, 2'd0, 2'd2);
    step();
    checks++;
    if (m_valid !== 3'b010 || m_data !== 2'd1 || sif.ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_full got v=%b d=%0d r=%b want v=010 d=1 r=0",
               m_valid, m_data, sif.ready);
    end
    drive(1'b1, 2'd2, 2'd3);
    step();
    checks++;
    if (m_valid !== 3'b010 || sif.ready !== 1'b0) begin
      errors++;
      $display("FAIL stall_hold got v=%b r=%b want v=010 r=0",
               m_valid, sif.ready);
    end
    m_ready = 3'b111;
    step();
    checks++;
    if (m_valid !== 3'b001 || m_data !== 2'd2 || sif.ready !== 1'b1) begin
      errors++;
      $display("FAIL stall_second got v=%b d=%0d r=%b want v=001 d=2 r=1",
               m_valid, m_data, sif.ready);
    end
    step();
    checks++;
    if (m_valid !== 3'b100 || m_data !== 2'd3) begin
      errors++;
      $display("FAIL stall_third got v=%b d=%0d want v=100 d=3",
               m_valid, m_data);
    end
    drive(1'b0, '0, '0);
    step();
    checks++;
    if (m_valid !== 3'b000) begin
      errors++;
      $display("FAIL stall_drain got %b want 000", m_valid);
    end
  endtask

  task automatic test_invalid();
    drive(1'b1, 2'd3, 2'd2);
    step();
    checks++;
    if (m_valid !== 3'b000 || sif.ready !== 1'b1) begin
      errors++;
      $display("FAIL inv_absorb got v=%b r=%b want v=000 r=1",
               m_valid, sif.ready);
    end
    checks++;
    if (err !== 1'b1 || err_id !== 2'd3 || err_cnt !== 8'd1) begin
      errors++;
      $display("FAIL inv_first got %b/%0d/%0d want 1/3/1",
               err, err_id, err_cnt);
    end
    step();
    checks++;
    if (err_cnt !== 8'd2 || err_id !== 2'd3 || m_valid !== 3'b000) begin
      errors++;
      $display("FAIL inv_second got cnt=%0d id=%0d v=%b want 2/3/000",
               err_cnt, err_id, m_valid);
    end
    drive(1'b0, '0, '0);
  endtask

  task automatic test_saturate();
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    checks++;
    if ({err, err_id, err_cnt} !== 11'h0) begin
      errors++;
      $display("FAIL sat_clear got %b/%0d/%0d want 0/0/0",
               err, err_id, err_cnt);
    end
    drive(1'b1, 2'd3, 2'd0);
    for (int i = 0; i < 260; i++) step();
    checks++;
    if (err_cnt !== 8'd255 || err !== 1'b1) begin
      errors++;
      $display("FAIL sat_255 got cnt=%0d err=%b want 255/1", err_cnt, err);
    end
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    drive(1'b0, '0, '0);
    checks++;
    if (err_cnt !== 8'd1 || err !== 1'b1 || err_id !== 2'd3) begin
      errors++;
      $display("FAIL sat_clr_win got %b/%0d/%0d want 1/3/1",
               err, err_id, err_cnt);
    end
  endtask

  task automatic test_reset_full();
    m_ready = 3'b000;
    drive(1'b1, 2'd0, 2'd1);
    step();
    drive(1'b1, 2'd1, 2'd2);
    step();
    drive(1'b0, '0, '0);
    checks++;
    if (sif.ready !== 1'b0 || m_valid !== 3'b001) begin
      errors++;
      $display("FAIL rf_full got r=%b v=%b want r=0 v=001",
               sif.ready, m_valid);
    end
    #2 aresetn = 1'b0;
    #1;
    checks++;
    if (m_valid !== 3'b000 || sif.ready !== 1'b1 ||
        {m_id, m_data} !== 4'h0) begin
      errors++;
      $display("FAIL rf_async_bus got v=%b r=%b id=%0d d=%0d want 000/1/0/0",
               m_valid, sif.ready, m_id, m_data);
    end
    checks++;
    if ({err, err_id, err_cnt} !== 11'h0) begin
      errors++;
      $display("FAIL rf_async_err got %b/%0d/%0d want 0/0/0",
               err, err_id, err_cnt);
    end
    step();
    aresetn = 1'b1;
    m_ready = 3'b111;
    drive(1'b1, 2'd2, 2'd2);
    step();
    drive(1'b0, '0, '0);
    checks++;
    if (m_valid !== 3'b100 || m_id !== 2'd2 || m_data !== 2'd2) begin
      errors++;
      $display("FAIL rf_route got v=%b id=%0d d=%0d want 100/2/2",
               m_valid, m_id, m_data);
    end
    step();
  endtask

  typedef struct {
    logic [IW-1:0] id;
    logic [PW-1:0] data;
  } beat_t;

  task automatic test_random();
    beat_t         q[$];
    beat_t         b;
    int            exp_cnt;
    logic [NP-1:0] ev;
    logic          ret;
    logic          acc;
    exp_cnt = 0;
    for (int c = 0; c < 400; c++) begin
      checks++;
      if (sif.ready !== (q.size() < 2)) begin
        errors++;
        $display("FAIL rnd_ready c=%0d got %b want %b",
                 c, sif.ready, q.size() < 2);
      end
      checks++;
      if ($countones(m_valid) > 1 || ((m_valid != 0) != (q.size() > 0))) begin
        errors++;
        $display("FAIL rnd_valid c=%0d got %b want occupancy %0d",
                 c, m_valid, q.size());
      end
      if (q.size() > 0) begin
        ev = NP'(1) << q[0].id;
        checks++;
        if (m_valid !== ev || m_id !== q[0].id || m_data !== q[0].data) begin
          errors++;
          $display("FAIL rnd_head c=%0d got v=%b id=%0d d=%0d want v=%b id=%0d d=%0d",
                   c, m_valid, m_id, m_data, ev, q[0].id, q[0].data);
        end
      end
      m_ready = ($urandom_range(0, 3) == 0) ? NP'($urandom) : '1;
      drive(1'($urandom), IW'($urandom), PW'($urandom));
      ret = |(m_valid & m_ready);
      acc = sif.valid && sif.ready;
      if (ret && q.size() > 0) void'(q.pop_front());
      if (acc && s_id < IW'(NP)) begin
        b.id   = s_id;
        b.data = sif.data;
        q.push_back(b);
      end else if (acc && exp_cnt < 255) begin
        exp_cnt++;
      end
      step();
    end
    drive(1'b0, '0, '0);
    checks++;
    if (err_cnt !== 8'(exp_cnt)) begin
      errors++;
      $display("FAIL rnd_errcnt got %0d want %0d", err_cnt, exp_cnt);
    end
  endtask

  initial begin
    test_reset();
    test_back_to_back();
    test_stall();
    test_invalid();
    test_saturate();
    test_reset_full();
    test_random();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
